// File: rtl/sockit_spi_sched.sv
// sockit_spi_sched: round-robin scheduler sharing the SPI stream-data-write
// (sdw) channel among N requesters. A winner owns the channel for a burst of
// req_len+1 words; the grant stays locked until the last word handshakes.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_vld, req_len  per-requester burst request and length-minus-one
//   gnt               registered one-hot grant
//   src_vld, src_dat  per-requester data stream
//   src_rdy           per-requester ready (only the granted one can see 1)
//   sdw_vld, sdw_dat  muxed stream toward the serializer
//   sdw_rdy           serializer ready
//   busy              high while a burst is in progress
//   err               one-cycle stall-timeout pulse
//
// Optional feature: define SOCKIT_SPI_SCHED_TIMEOUT_EN to abort a burst whose
// granted requester leaves sdw_vld low for TO consecutive cycles. Without it
// err is tied low and a stalled requester keeps the grant indefinitely.
module sockit_spi_sched #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 8,
  parameter int unsigned TO = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_vld,
  input  logic [N*CW-1:0] req_len,
  output logic [N-1:0]    gnt,
  input  logic [N-1:0]    src_vld,
  input  logic [N*DW-1:0] src_dat,
  output logic [N-1:0]    src_rdy,
  output logic            sdw_vld,
  output logic [DW-1:0]   sdw_dat,
  input  logic            sdw_rdy,
  output logic            busy,
  output logic            err
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    gnt_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic            busy_nxt;
  logic            hs;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  int unsigned     scan_idx;

`ifdef SOCKIT_SPI_SCHED_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TO + 1);
  logic [SW-1:0]   stall, stall_nxt;
  logic            err_q, err_nxt;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Rotating-priority scan: first set request at or after ptr, modulo N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = (32'(ptr) + k) % N;
      if (!pick_found && req_vld[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(scan_idx);
      end
    end
  end

  // Datapath: gnt is one-hot or zero, so an OR-reduction mux suffices.
  always_comb begin
    sdw_dat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) sdw_dat = sdw_dat | src_dat[i*DW +: DW];
    end
  end

  assign sdw_vld = |(gnt & src_vld);
  assign src_rdy = gnt & {N{sdw_rdy}};
  assign hs      = sdw_vld & sdw_rdy;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    busy_nxt  = busy;
`ifdef SOCKIT_SPI_SCHED_TIMEOUT_EN
    stall_nxt = stall;
    err_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef SOCKIT_SPI_SCHED_TIMEOUT_EN
        stall_nxt = '0;
`endif
        if (pick_found) begin
          state_nxt = XFER;
          gnt_nxt   = N'(1) << pick_idx;
          cnt_nxt   = req_len[pick_idx*CW +: CW];
          ptr_nxt   = PW'((32'(pick_idx) + 32'd1) % N);
          busy_nxt  = 1'b1;
        end
      end
      XFER: begin
        if (hs) begin
`ifdef SOCKIT_SPI_SCHED_TIMEOUT_EN
          stall_nxt = '0;
`endif
          if (cnt == '0) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
`ifdef SOCKIT_SPI_SCHED_TIMEOUT_EN
        // Only an absent source counts as a stall; serializer backpressure does not.
        else if (!sdw_vld) begin
          if (stall == SW'(TO - 1)) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
            stall_nxt = '0;
            err_nxt   = 1'b1;
          end else begin
            stall_nxt = stall + SW'(1);
          end
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      cnt   <= '0;
      ptr   <= '0;
      busy  <= 1'b0;
`ifdef SOCKIT_SPI_SCHED_TIMEOUT_EN
      stall <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      busy  <= busy_nxt;
`ifdef SOCKIT_SPI_SCHED_TIMEOUT_EN
      stall <= stall_nxt;
      err_q <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sockit_spi_sched.sv
module tb_sockit_spi_sched;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_vld = '0;
  logic [N*CW-1:0] req_len = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    src_vld = '0;
  logic [N*DW-1:0] src_dat = '0;
  logic [N-1:0]    src_rdy;
  logic            sdw_vld;
  logic [DW-1:0]   sdw_dat;
  logic            sdw_rdy = 1'b0;
  logic            busy;
  logic            err;

  sockit_spi_sched #(.N(N), .DW(DW), .CW(CW), .TO(TO)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_len(req_len), .gnt(gnt),
    .src_vld(src_vld), .src_dat(src_dat), .src_rdy(src_rdy),
    .sdw_vld(sdw_vld), .sdw_dat(sdw_dat), .sdw_rdy(sdw_rdy),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sources: requester i presents word ((i+1)<<28)+seq[i], advancing after each handshake.
  int unsigned seq [N];
  logic [N-1:0] src_hs;
  initial begin
    for (int unsigned i = 0; i < N; i++) seq[i] = 0;
    for (int unsigned i = 0; i < N; i++) src_dat[i*DW +: DW] = ((i + 1) << 28) + seq[i];
    forever begin
      @(negedge clk);
      src_hs = src_vld & src_rdy;
      @(posedge clk);
      #1;
      for (int unsigned i = 0; i < N; i++) begin
        if (src_hs[i]) seq[i]++;
        src_dat[i*DW +: DW] = ((i + 1) << 28) + seq[i];
      end
    end
  end

  // Reference model: owner of the channel and words still owed in its burst.
  int          m_owner;
  int unsigned m_left, m_ptr, m_stall;
  logic        m_err;
  initial begin
    m_owner = -1; m_left = 0; m_ptr = 0; m_stall = 0; m_err = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      m_err = 1'b0;
      if (rst) begin
        m_owner = -1; m_left = 0; m_ptr = 0; m_stall = 0;
      end else if (m_owner < 0) begin
        m_stall = 0;
        for (int unsigned k = 0; k < N; k++) begin
          int unsigned j;
          j = (m_ptr + k) % N;
          if (m_owner < 0 && req_vld[j]) begin
            m_owner = j;
            m_left  = req_len[j*CW +: CW] + 1;
            m_ptr   = (j + 1) % N;
          end
        end
      end else begin
        if (src_vld[m_owner] && sdw_rdy) begin
          m_stall = 0;
          m_left--;
          if (m_left == 0) m_owner = -1;
        end
`ifdef SOCKIT_SPI_SCHED_TIMEOUT_EN
        else if (!src_vld[m_owner]) begin
          m_stall++;
          if (m_stall == TO) begin
            m_owner = -1; m_left = 0; m_stall = 0; m_err = 1'b1;
          end
        end
`endif
      end
    end
  end

  // Compare process: every cycle, all outputs against the model.
  logic [N-1:0]  e_gnt;
  logic [DW-1:0] e_dat;
  initial begin
    forever begin
      @(negedge clk);
      e_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      e_dat = (m_owner < 0) ? '0 : src_dat[m_owner*DW +: DW];
      chk("gnt", gnt, e_gnt);
      chk("busy", busy, m_owner >= 0);
      chk("sdw_vld", sdw_vld, (m_owner >= 0) && src_vld[m_owner]);
      chk("sdw_dat", sdw_dat, e_dat);
      chk("src_rdy", src_rdy, sdw_rdy ? e_gnt : '0);
      chk("err", err, m_err);
    end
  end

  // Monitor: logs of accepted words, grant order/time, busy cycles.
  logic [DW-1:0] obs [$];
  int unsigned   gnt_log [$];
  int unsigned   gnt_cyc [$];
  int unsigned   busy_cnt = 0, rdy0_cnt = 0, err_cnt = 0, cyc = 0;
  logic [N-1:0]  prev_gnt = '0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    int unsigned gi;
    forever begin
      @(negedge clk);
      if (sdw_vld && sdw_rdy) obs.push_back(sdw_dat);
      if (gnt != '0 && prev_gnt == '0) begin
        gi = 0;
        for (int unsigned i = 0; i < N; i++) if (gnt[i]) gi = i;
        gnt_log.push_back(gi);
        gnt_cyc.push_back(cyc);
      end
      prev_gnt = gnt;
      if (busy) busy_cnt++;
      if (src_rdy[0]) rdy0_cnt++;
      if (err) err_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    obs.delete(); gnt_log.delete(); gnt_cyc.delete();
    busy_cnt = 0; rdy0_cnt = 0; err_cnt = 0;
  endtask

  task automatic wait_grant(input int unsigned budget, input string name);
    int unsigned c = 0;
    while (gnt == '0 && c < budget) begin step(); c++; end
    chk(name, gnt != '0, 1'b1);
  endtask

  task automatic wait_idle(input int unsigned budget, input string name);
    int unsigned c = 0;
    while (busy && c < budget) begin step(); c++; end
    chk(name, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0, s1, c, held;
    logic started;
    int unsigned exp_order [4];
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;

    // Reset state
    step(); step();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_sdw_vld", sdw_vld, 1'b0);
    chk("rst_src_rdy", src_rdy, 2'b00);
    rst = 1'b0;
    step();

    // 1: single 4-word burst from requester 0
    clear_logs();
    s0 = seq[0];
    req_len = {8'd0, 8'd3}; req_vld = 2'b01; src_vld = 2'b01; sdw_rdy = 1'b1;
    @(negedge clk); #1;
    chk("t1_gnt_before_edge", gnt, 2'b00);
    @(negedge clk); #1;
    chk("t1_gnt_latency", gnt, 2'b01);
    step();
    req_vld = 2'b00;
    wait_idle(20, "t1_idle");
    chk("t1_words", obs.size(), 4);
    for (int unsigned k = 0; k < obs.size(); k++)
      chk("t1_word", obs[k], 32'h1000_0000 + s0 + k);
    chk("t1_busy_cycles", busy_cnt, 4);
    chk("t1_gnt_after", gnt, 2'b00);
    src_vld = 2'b00;

    // 2: both request single words after reset -> 0,1,0,1 with one idle cycle between
    rst = 1'b1; step(); step(); rst = 1'b0;
    clear_logs();
    req_len = '0; req_vld = 2'b11; src_vld = 2'b11; sdw_rdy = 1'b1;
    c = 0;
    while (gnt_log.size() < 4 && c < 40) begin @(negedge clk); #1; c++; end
    step();
    req_vld = 2'b00;
    wait_idle(10, "t2_idle");
    chk("t2_grants", gnt_log.size(), 4);
    for (int unsigned k = 0; k < gnt_log.size() && k < 4; k++)
      chk("t2_order", gnt_log[k], exp_order[k]);
    for (int unsigned k = 1; k < gnt_cyc.size(); k++)
      chk("t2_gap", gnt_cyc[k] - gnt_cyc[k-1], 2);
    src_vld = 2'b00;

    // 3: requester 1, 5 words, sdw_rdy toggling; requester 0 valid but never granted
    clear_logs();
    s0 = seq[0]; s1 = seq[1];
    req_len = {8'd4, 8'd0}; req_vld = 2'b10; src_vld = 2'b11; sdw_rdy = 1'b1;
    started = 1'b0;
    for (int unsigned k = 0; k < 60; k++) begin
      step();
      sdw_rdy = ~sdw_rdy;
      if (gnt != '0) begin req_vld = 2'b00; started = 1'b1; end
      if (started && !busy) break;
    end
    chk("t3_done", started && !busy, 1'b1);
    chk("t3_words", obs.size(), 5);
    for (int unsigned k = 0; k < obs.size(); k++)
      chk("t3_word", obs[k], 32'h2000_0000 + s1 + k);
    chk("t3_src_rdy0", rdy0_cnt, 0);
    chk("t3_src0_untouched", seq[0], s0);
    sdw_rdy = 1'b1; src_vld = 2'b00;

    // 4: reset after 2 of 5 words, then requester 0 wins first
    clear_logs();
    req_len = {8'd4, 8'd0}; req_vld = 2'b10; src_vld = 2'b10; sdw_rdy = 1'b1;
    wait_grant(5, "t4_grant");
    req_vld = 2'b00;
    c = 0;
    while (obs.size() < 2 && c < 20) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t4_words_before_rst", obs.size(), 2);
    chk("t4_rst_gnt", gnt, 2'b00);
    chk("t4_rst_sdw_vld", sdw_vld, 1'b0);
    chk("t4_rst_busy", busy, 1'b0);
    req_len = '0; req_vld = 2'b11; src_vld = 2'b11;
    step();
    clear_logs();
    step();
    rst = 1'b0;
    c = 0;
    while (gnt_log.size() < 2 && c < 20) begin @(negedge clk); #1; c++; end
    step();
    req_vld = 2'b00;
    wait_idle(10, "t4_idle");
    chk("t4_grants", gnt_log.size(), 2);
    if (gnt_log.size() >= 2) begin
      chk("t4_first", gnt_log[0], 0);
      chk("t4_second", gnt_log[1], 1);
    end
    src_vld = 2'b00;

    // 5: maximum burst, 256 words
    clear_logs();
    s0 = seq[0];
    req_len = {8'd0, 8'd255}; req_vld = 2'b01; src_vld = 2'b01; sdw_rdy = 1'b1;
    wait_grant(5, "t5_grant");
    req_vld = 2'b00;
    wait_idle(300, "t5_idle");
    chk("t5_words", obs.size(), 256);
    if (obs.size() == 256) begin
      chk("t5_first", obs[0], 32'h1000_0000 + s0);
      chk("t5_last", obs[255], 32'h1000_0000 + s0 + 255);
    end
    chk("t5_busy_cycles", busy_cnt, 256);
    step();
    chk("t5_released", gnt, 2'b00);
    src_vld = 2'b00;

    // 6: granted source stalls
    clear_logs();
    req_len = {8'd0, 8'd3}; req_vld = 2'b01; src_vld = 2'b00; sdw_rdy = 1'b1;
    wait_grant(5, "t6_grant");
    req_vld = 2'b00;
`ifdef SOCKIT_SPI_SCHED_TIMEOUT_EN
    req_len = {8'd0, 8'd3}; req_vld = 2'b10; src_vld = 2'b10;
    c = 0;
    while (err_cnt == 0 && c < 40) begin step(); c++; end
    step();
    chk("t6_err_pulses", err_cnt, 1);
    wait_grant(5, "t6_next_grant");
    chk("t6_next_owner", gnt, 2'b10);
    req_vld = 2'b00;
    wait_idle(10, "t6_idle");
    chk("t6_err_once", err_cnt, 1);
`else
    held = 0;
    repeat (100) begin
      step();
      if (gnt == 2'b01) held++;
    end
    chk("t6_held", held, 100);
    chk("t6_no_err", err_cnt, 0);
    src_vld = 2'b01;
    wait_idle(20, "t6_idle");
    chk("t6_words", obs.size(), 4);
`endif
    src_vld = 2'b00;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
